// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage feeding a shift-left register
//
// Accepts a width-bit word over a valid/ready handshake and streams it MSB-first
// on ser_d, with ser_en qualifying each bit. A back-to-back word is accepted in
// the last-bit cycle, so consecutive words stream with no idle cycle.
//
// Optional feature macro: PISO_PARITY_EN
//   When defined, an extra bit carrying the even parity (XOR reduction) of the word
//   follows bit 0, so each word occupies width+1 ser_en cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    parallel word to serialize (held stable until accepted)
//   in_valid   in_data valid
//   in_ready   block can accept a word this cycle (combinational)
//   ser_d      serial data bit, MSB-first, registered
//   ser_en     ser_d valid this cycle, registered
//   word_done  one-cycle pulse: downstream register now holds the full word
//   busy       high while in SHIFT state

module piso_serializer #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_d,
  output logic             ser_en,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(width + 1);

  // Counter value loaded on accept; the counter reaches zero on the final
  // serial cycle of the word (bit 0, or the parity bit when enabled).
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(width);
`else
  localparam logic [CW-1:0] LAST = CW'(width - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [width-1:0] shreg, shreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_d_d, ser_en_d, word_done_d;
  logic             accept;
  logic             last_cycle;

`ifdef PISO_PARITY_EN
  logic             par, par_d;
`endif

  assign last_cycle = (state == SHIFT) && (cnt == '0);
  assign in_ready   = (state == IDLE) || last_cycle;
  assign accept     = in_valid && in_ready;
  assign busy       = (state == SHIFT);

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    cnt_d       = cnt;
    ser_d_d     = ser_d;
    ser_en_d    = ser_en;
    word_done_d = last_cycle;
`ifdef PISO_PARITY_EN
    par_d       = par;
`endif

    if (accept) begin
      // Fresh load, also taken in the last-bit cycle so ser_en never drops
      // between consecutive words.
      state_d  = SHIFT;
      shreg_d  = in_data;
      cnt_d    = LAST;
      ser_d_d  = in_data[width-1];
      ser_en_d = 1'b1;
`ifdef PISO_PARITY_EN
      par_d    = ^in_data;
`endif
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        // shreg[width-1] is the bit currently on ser_d, so the next bit
        // sits one position below it.
        shreg_d = {shreg[width-2:0], 1'b0};
        cnt_d   = cnt - CW'(1);
        ser_d_d = shreg[width-2];
`ifdef PISO_PARITY_EN
        if (cnt == CW'(1)) begin
          ser_d_d = par;
        end
`endif
      end else begin
        state_d  = IDLE;
        ser_en_d = 1'b0;
        ser_d_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_d     <= 1'b0;
      ser_en    <= 1'b0;
      word_done <= 1'b0;
`ifdef PISO_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      cnt       <= cnt_d;
      ser_d     <= ser_d_d;
      ser_en    <= ser_en_d;
      word_done <= word_done_d;
`ifdef PISO_PARITY_EN
      par       <= par_d;
`endif
    end
  end

endmodule
